prog_loader: RTL

//  Byte-stream boot loader that writes a program image into the core's instruction

---
 rtl/prog_loader_pkg.sv | 25 ++
 rtl/prog_loader_byte_packer.sv | 56 +++++
 rtl/prog_loader.sv | 138 +++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot loader: frame field widths, FSM state
// encoding and a small helper that tells which states take stream bytes.
package prog_loader_pkg;

   localparam int BYTE_W         = 8;
   localparam int WORD_W         = 32;
   localparam int LEN_W          = 16;
   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEN_LO = 3'd1,
      ST_LEN_HI = 3'd2,
      ST_DATA   = 3'd3,
      ST_CSUM   = 3'd4,
      ST_DONE   = 3'd5,
      ST_ERROR  = 3'd6
   } state_t;

   // True for the states in which a frame is being received.
   function automatic logic inFrame(input state_t s);
      return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CSUM);
   endfunction

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Little-endian byte-to-word assembler. Collects four bytes (first byte lands
// in bits [7:0]) and emits a one-cycle word_valid with the finished word on
// the cycle after the fourth byte arrives.
module prog_loader_byte_packer
   import prog_loader_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_clear,
   input  logic              i_byteValid,
   input  logic [BYTE_W-1:0] i_byteData,
   output logic [1:0]        o_byteCount,
   output logic              o_wordValid,
   output logic [WORD_W-1:0] o_word
);

   localparam logic [1:0] LastByte = 2'(BYTES_PER_WORD - 1);

   logic [WORD_W-BYTE_W-1:0] r_shift;
   logic [1:0]               r_count;
   logic                     r_wordValid;
   logic [WORD_W-1:0]        r_word;

   // Shift bytes in from the top so the oldest byte ends up lowest; the
   // fourth byte completes the word and raises word_valid for one cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_shift     <= '0;
         r_count     <= '0;
         r_wordValid <= 1'b0;
         r_word      <= '0;
      end else if (i_clear) begin
         r_shift     <= '0;
         r_count     <= '0;
         r_wordValid <= 1'b0;
      end else begin
         r_wordValid <= 1'b0;
         if (i_byteValid) begin
            if (r_count == LastByte) begin
               r_word      <= {i_byteData, r_shift};
               r_wordValid <= 1'b1;
               r_count     <= '0;
               r_shift     <= '0;
            end else begin
               r_shift <= {i_byteData, r_shift[WORD_W-BYTE_W-1:BYTE_W]};
               r_count <= r_count + 2'd1;
            end
         end
      end
   end

   assign o_byteCount = r_count;
   assign o_wordValid = r_wordValid;
   assign o_word      = r_word;

endmodule

// File: rtl/prog_loader.sv
// Byte-stream boot loader. Receives a length-prefixed, XOR-checksummed program
// image, writes it word by word into instruction memory and keeps the core in
// reset until the whole image has arrived with a matching checksum.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int ADDR_W    = 10,
   parameter int MAX_WORDS = 1024
)
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_in_valid,
   input  logic [BYTE_W-1:0] i_in_data,
   output logic              o_in_ready,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [WORD_W-1:0] o_mem_wdata,
   output logic              o_core_rst_n,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err
);

   localparam logic [LEN_W-1:0] MaxWordsL = LEN_W'(MAX_WORDS);

   state_t             r_state;
   state_t             w_nextState;
   logic [BYTE_W-1:0]  r_lenLo;
   logic [LEN_W-1:0]   r_len;
   logic [LEN_W-1:0]   r_wordIdx;
   logic [BYTE_W-1:0]  r_xor;
   logic [ADDR_W-1:0]  r_memAddr;

   logic               w_accept;
   logic               w_startOk;
   logic [LEN_W-1:0]   w_lenFull;
   logic               w_dataByte;
   logic               w_wordEnd;
   logic               w_lastWord;
   logic [1:0]         w_byteCount;
   logic               w_wordValid;
   logic [WORD_W-1:0]  w_word;

   assign w_accept   = i_in_valid & o_in_ready;
   assign w_startOk  = i_start & ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                  (r_state == ST_ERROR));
   assign w_lenFull  = {i_in_data, r_lenLo};
   assign w_dataByte = w_accept & (r_state == ST_DATA);
   assign w_wordEnd  = w_dataByte & (w_byteCount == 2'd3);
   assign w_lastWord = w_wordEnd & ((r_wordIdx + 16'd1) == r_len);

   prog_loader_byte_packer u_packer (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_clear     (w_startOk),
      .i_byteValid (w_dataByte),
      .i_byteData  (i_in_data),
      .o_byteCount (w_byteCount),
      .o_wordValid (w_wordValid),
      .o_word      (w_word)
   );

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Frame sequencing: length bytes, payload words, checksum, then a sticky
   // DONE/ERROR outcome that only a new start leaves.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (i_start) w_nextState = ST_LEN_LO;
         end
         ST_LEN_LO: begin
            if (w_accept) w_nextState = ST_LEN_HI;
         end
         ST_LEN_HI: begin
            if (w_accept) begin
               if (w_lenFull > MaxWordsL)   w_nextState = ST_ERROR;
               else if (w_lenFull == '0)    w_nextState = ST_CSUM;
               else                         w_nextState = ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_lastWord) w_nextState = ST_CSUM;
         end
         ST_CSUM: begin
            if (w_accept) w_nextState = (i_in_data == r_xor) ? ST_DONE : ST_ERROR;
         end
         default: w_nextState = ST_IDLE;
      endcase
   end

   // Status and handshake outputs decoded purely from the current state.
   always_comb begin
      o_in_ready   = inFrame(r_state);
      o_busy       = inFrame(r_state);
      o_done       = (r_state == ST_DONE);
      o_err        = (r_state == ST_ERROR);
      o_core_rst_n = (r_state == ST_DONE);
   end

   // Frame bookkeeping: captured length, running word index, running XOR and
   // the address that accompanies the packer's write strobe.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_lenLo   <= '0;
         r_len     <= '0;
         r_wordIdx <= '0;
         r_xor     <= '0;
         r_memAddr <= '0;
      end else if (w_startOk) begin
         r_wordIdx <= '0;
         r_xor     <= '0;
      end else begin
         if ((r_state == ST_LEN_LO) && w_accept) r_lenLo <= i_in_data;
         if ((r_state == ST_LEN_HI) && w_accept) r_len   <= w_lenFull;
         if (w_dataByte) r_xor <= r_xor ^ i_in_data;
         if (w_wordEnd) begin
            r_memAddr <= r_wordIdx[ADDR_W-1:0];
            r_wordIdx <= r_wordIdx + 16'd1;
         end
      end
   end

   assign o_mem_we    = w_wordValid;
   assign o_mem_addr  = r_memAddr;
   assign o_mem_wdata = w_word;

endmodule
